// File: rtl/usb_fifo_bridge_if.sv
// Fabric-side port bundle of usb_fifo_bridge: TX word push with level/overflow
// status, and the first-word-fall-through RX byte stream.
interface usb_fifo_bridge_if #(
    parameter int WORD_BYTES    = 1,
    parameter int FIFO_LOG_SIZE = 13
);
    // tx_wr pushes tx_data on any cycle it is high and there is no backpressure:
    // a push while full is dropped, so producers watch tx_space. rx_data/rx_valid
    // present the RX head; it is consumed on a cycle where rx_valid and rx_rd are high.
    logic [8*WORD_BYTES-1:0] tx_data;
    logic                    tx_wr;
    logic                    tx_space;
    logic [FIFO_LOG_SIZE:0]  tx_level;
    logic                    tx_overflow;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_rd;

    modport master (
        output tx_data, tx_wr, rx_rd,
        input  tx_space, tx_level, tx_overflow, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_wr, rx_rd,
        output tx_space, tx_level, tx_overflow, rx_data, rx_valid
    );
endinterface

// File: rtl/usb_fifo_bridge.sv
// Deep TX word FIFO serialised onto an FT245-style 8-bit FIFO bus with byte retry.
// Define USB_RX_EN to add the host-to-FPGA RX path, which shares the bus.
module usb_fifo_bridge #(
    parameter int WORD_BYTES     = 1,
    parameter int FIFO_LOG_SIZE  = 13,
    parameter int FIFO_THRESHOLD = 8,
    parameter int RX_LOG_SIZE    = 9
) (
    input  logic             mclk,
    input  logic             reset,
    inout  wire  [7:0]       usb_d,
    input  logic             usb_rxf_n,
    input  logic             usb_txe_n,
    output logic             usb_rd_n,
    output logic             usb_wr_n,
    output logic             usb_oe_n,
    usb_fifo_bridge_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam int W     = 8 * WORD_BYTES;
    localparam int DEPTH = 1 << FIFO_LOG_SIZE;
    localparam int LW    = FIFO_LOG_SIZE + 2;
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TX_STB = 3'd1;
    localparam logic [2:0] S_TX_CHK = 3'd2;
`ifdef USB_RX_EN
    localparam logic [2:0] S_TURN   = 3'd3;
    localparam logic [2:0] S_RX_OE  = 3'd4;
    localparam logic [2:0] S_RX_RD1 = 3'd5;
    localparam logic [2:0] S_RX_RD2 = 3'd6;
`endif

    logic [2:0]             state_q, state_d;
    logic [W-1:0]           word_q, word_d;
    logic [1:0]             idx_q, idx_d;
    logic                   word_vld_q, word_vld_d;
    logic                   pend_q, pend_d;
    logic                   prefer_rx_q, prefer_rx_d;
    logic                   tx_ovf_q, tx_ovf_d;
    logic [FIFO_LOG_SIZE:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [W-1:0]           tx_mem [DEPTH];

    logic [FIFO_LOG_SIZE:0] tx_level;
    logic                   tx_full, tx_empty, tx_push, tx_pop;
    logic                   tx_ready, rx_ready, pick_rx, pick_tx;
    logic                   go_tx, go_rx, rx_push;
    logic [7:0]             tx_byte;

    // ---------------- TX FIFO ----------------
    assign tx_level = tx_wp_q - tx_rp_q;
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[FIFO_LOG_SIZE] != tx_rp_q[FIFO_LOG_SIZE]) &&
                      (tx_wp_q[FIFO_LOG_SIZE-1:0] == tx_rp_q[FIFO_LOG_SIZE-1:0]);
    assign tx_push  = bus.tx_wr && !tx_full;
    assign tx_wp_d  = tx_wp_q + (FIFO_LOG_SIZE+1)'(tx_push);
    assign tx_rp_d  = tx_rp_q + (FIFO_LOG_SIZE+1)'(tx_pop);
    assign tx_ovf_d = tx_ovf_q || (bus.tx_wr && tx_full);

    assign bus.tx_level    = tx_level;
    assign bus.tx_overflow = tx_ovf_q;
    assign bus.tx_space    = (LW'(tx_level) + LW'(FIFO_THRESHOLD)) <= LW'(DEPTH);

    always_ff @(posedge mclk) begin
        if (tx_push) tx_mem[tx_wp_q[FIFO_LOG_SIZE-1:0]] <= bus.tx_data;
    end

    always_comb begin
        tx_byte = 8'h00;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (idx_q == 2'(b)) tx_byte = word_q[8*b +: 8];
        end
    end

    // ---------------- Arbitration ----------------
    // A pending (rejected) byte keeps word_vld_q set and suppresses RX entirely.
    assign tx_ready = (word_vld_q || !tx_empty) && !usb_txe_n;
    assign pick_rx  = rx_ready && (!tx_ready || prefer_rx_q);
    assign pick_tx  = tx_ready && !pick_rx;

    // ---------------- Bus FSM ----------------
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        word_vld_d  = word_vld_q;
        pend_d      = pend_q;
        prefer_rx_d = prefer_rx_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        go_tx       = 1'b0;
        go_rx       = 1'b0;
        case (state_q)
            S_IDLE: begin
                go_tx = pick_tx;
                go_rx = pick_rx;
            end
            S_TX_STB: state_d = S_TX_CHK;
            S_TX_CHK: begin
                state_d = S_IDLE;
                if (usb_txe_n) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        word_vld_d = 1'b0;
                        idx_d      = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                    // Chaining straight into the next strobe gives one byte per two cycles.
                    go_tx = ((idx_q != LAST_IDX) || !tx_empty) && !rx_ready;
                end
            end
`ifdef USB_RX_EN
            S_RX_OE:  state_d = S_RX_RD1;
            S_RX_RD1: state_d = S_RX_RD2;
            S_RX_RD2: begin
                rx_push = 1'b1;
                state_d = S_TURN;
            end
            S_TURN:   state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
        if (go_tx) begin
            state_d     = S_TX_STB;
            prefer_rx_d = 1'b1;
            if (!word_vld_d) begin
                tx_pop     = 1'b1;
                word_d     = tx_mem[tx_rp_q[FIFO_LOG_SIZE-1:0]];
                idx_d      = 2'd0;
                word_vld_d = 1'b1;
            end
        end
        if (go_rx) begin
`ifdef USB_RX_EN
            state_d = S_RX_OE;
`endif
            prefer_rx_d = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            word_vld_q  <= 1'b0;
            pend_q      <= 1'b0;
            prefer_rx_q <= 1'b1;
            tx_ovf_q    <= 1'b0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_vld_q  <= word_vld_d;
            pend_q      <= pend_d;
            prefer_rx_q <= prefer_rx_d;
            tx_ovf_q    <= tx_ovf_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
        end
    end

    always_ff @(posedge mclk) begin
        word_q <= word_d;
    end

    assign usb_wr_n  = (state_q != S_TX_STB);
    assign dbg_state = state_q;

`ifdef USB_RX_EN
    // ---------------- RX FIFO (first-word-fall-through) ----------------
    localparam int RX_DEPTH = 1 << RX_LOG_SIZE;
    logic [7:0]           rx_mem [RX_DEPTH];
    logic [RX_LOG_SIZE:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic                 rx_full, rx_empty, rx_pop;

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[RX_LOG_SIZE] != rx_rp_q[RX_LOG_SIZE]) &&
                      (rx_wp_q[RX_LOG_SIZE-1:0] == rx_rp_q[RX_LOG_SIZE-1:0]);
    assign rx_pop   = bus.rx_rd && !rx_empty;
    assign rx_wp_d  = rx_wp_q + (RX_LOG_SIZE+1)'(rx_push);
    assign rx_rp_d  = rx_rp_q + (RX_LOG_SIZE+1)'(rx_pop);
    assign rx_ready = !usb_rxf_n && !rx_full && !pend_q;

    always_ff @(posedge mclk) begin
        if (rx_push) rx_mem[rx_wp_q[RX_LOG_SIZE-1:0]] <= usb_d;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_mem[rx_rp_q[RX_LOG_SIZE-1:0]];
    assign usb_oe_n     = !(state_q == S_RX_OE || state_q == S_RX_RD1 || state_q == S_RX_RD2);
    assign usb_rd_n     = !(state_q == S_RX_RD1 || state_q == S_RX_RD2);
    assign usb_d        = (state_q == S_IDLE || state_q == S_TX_STB || state_q == S_TX_CHK)
                          ? tx_byte : 8'hzz;
`else
    localparam int unused_rx_log = RX_LOG_SIZE;
    logic unused_rx_in;

    assign rx_ready     = 1'b0;
    assign bus.rx_valid = 1'b0;
    assign bus.rx_data  = 8'h00;
    assign usb_oe_n     = 1'b1;
    assign usb_rd_n     = 1'b1;
    assign usb_d        = tx_byte;
    assign unused_rx_in = usb_rxf_n ^ bus.rx_rd ^ rx_push;
`endif
endmodule

// File: doc/usb_fifo_bridge.md
# usb_fifo_bridge

Parametrised successor to the single-byte USB write streamer: buffers multi-byte words from fabric logic in a deep TX FIFO and serialises them onto an FT2232/FT245-style 8-bit FIFO bus, including the retry on rejected bytes. Adds level and overflow reporting and an optional host-to-FPGA receive path that shares the bus. Sits between the capture/sniffer cores and the USB pins at the top level.

## Interface
- WORD_BYTES, 1: bytes per TX word (1..4); tx_data width is 8*WORD_BYTES.
- FIFO_LOG_SIZE, 13: log2 of TX FIFO depth in words.
- FIFO_THRESHOLD, 8: minimum free words for tx_space=1.
- RX_LOG_SIZE, 9: log2 of RX FIFO depth in bytes (used only with USB_RX_EN).

- mclk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- usb_d  inout  8  FT bus data.
- usb_rxf_n  in  1  FT has RX data (low active).
- usb_txe_n  in  1  FT accepts writes (low active).
- usb_rd_n, usb_wr_n, usb_oe_n  out  1 each  FT strobes (low active).
- tx_data  in  8*WORD_BYTES  word to send; byte 0 = bits [7:0] goes first.
- tx_wr  in  1  push tx_data this cycle.
- tx_space  out  1  free words >= FIFO_THRESHOLD.
- tx_level  out  FIFO_LOG_SIZE+1  words stored.
- tx_overflow  out  1  sticky: a push was dropped.
- rx_data  out  8  head of RX FIFO (first-word-fall-through).
- rx_valid  out  1  rx_data valid.
- rx_rd  in  1  pop RX head when rx_valid=1.

## Operation
- TX FIFO: full capacity 2**FIFO_LOG_SIZE words; pointers carry one extra wrap bit; full = pointers equal except MSB.
- tx_wr while full: word discarded, tx_overflow<=1 until reset. tx_wr while not full: stored; tx_level+1 next cycle.
- Serialiser pops one word, sends bytes 0..WORD_BYTES-1 in order; next word popped after last byte's strobe.
- Bus FSM states: IDLE, TX_STB, TX_CHK, TURN, RX_OE, RX_RD1, RX_RD2.
- IDLE -> TX_STB when (byte available or pending) and usb_txe_n=0 and RX not selected.
- TX_STB: usb_wr_n=0 one cycle, usb_d = current byte. -> TX_CHK.
- TX_CHK: usb_wr_n=1; if usb_txe_n=1 this cycle, byte marked pending and re-sent unchanged on next TX_STB; else byte retired. -> IDLE.
- Pending byte has priority over everything; it is never dropped or reordered.
- Arbitration when TX and RX both ready and no pending byte: alternate, starting with RX after reset.
- RX selected only if usb_rxf_n=0 and RX FIFO has >=1 free entry. IDLE -> RX_OE (usb_d released, usb_oe_n=0) -> RX_RD1 (usb_rd_n=0) -> RX_RD2 (usb_rd_n=0, usb_d sampled at end of cycle and pushed) -> TURN (all strobes high, bus released) -> IDLE.
- usb_d driven in IDLE, TX_STB, TX_CHK; high-Z in RX_OE, RX_RD1, RX_RD2, TURN.
- rx_rd with rx_valid=0: ignored.

## Timing
- Reset values: usb_wr_n=1, usb_rd_n=1, usb_oe_n=1, tx_space=1, tx_level=0, tx_overflow=0, rx_valid=0, FSM=IDLE, pending cleared; FIFO contents not reset.
- tx_wr at cycle N (FIFO empty, usb_txe_n=0): first usb_wr_n low at N+2.
- Max TX rate: one byte per 2 cycles; WORD_BYTES=4 word takes 8 cycles.
- RX transaction: 5 cycles IDLE-to-IDLE; rx_valid rises the cycle after RX_RD2.
- tx_level/tx_space reflect simultaneous push and pop (net unchanged); push at full with simultaneous pop is still dropped.
- Reset mid-transaction: strobes high next edge, FIFOs emptied, partial word lost.

## Configuration
- USB_RX_EN defined: RX path, RX FIFO, RX states and arbitration as above.
- Undefined: RX states absent; usb_rd_n=usb_oe_n=1 constant; usb_d always driven; rx_valid=0, rx_data=0; rx_rd ignored; TX behaviour identical.

## Test plan
- WORD_BYTES=2, push 16'hA55A, txe_n=0 -> bytes 5A then A5 on usb_d with two wr_n low pulses, first at N+2.
- Hold txe_n=1 in TX_CHK of byte 8'h33 -> 8'h33 strobed again next TX_STB; no byte skipped, tx_level unaffected until retire.
- FIFO_LOG_SIZE=4, txe_n=1, push 17 words -> tx_level=16, tx_overflow=1, tx_space=0 from level 9 up (THRESHOLD=8).
- USB_RX_EN, rxf_n=0 presenting 8'hC3, txe_n=1 -> oe_n low, rd_n low 2 cycles, rx_valid=1 with rx_data=8'hC3; usb_d Z throughout.
- USB_RX_EN, TX and RX both ready continuously -> strict RX/TX alternation starting with RX; never overlapping oe_n low with usb_d driven.
- reset asserted during RX_RD1 -> next cycle all strobes high, tx_level=0, rx_valid=0.
